// File: rtl/mux_scan_n.sv
// Registered N:1 channel mux: direct select by sel, or a handshaked scan that
// emits each enabled channel once, lowest index first.
module mux_scan_n #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH*W-1:0] din,
  input  logic [N_CH-1:0]   en_mask,
  input  logic              start,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // S_IDLE | waiting; mode=0 enters direct, mode=1 & start launches a scan
  // S_DSEL | direct mode, registered din[sel] every cycle
  // S_SCAN | walking latched enabled channels, one per handshake
  typedef enum logic [1:0] {S_IDLE, S_DSEL, S_SCAN} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_CH-1:0]   r_mask, w_mask_nxt;
  logic [W-1:0]      r_data, w_data_nxt;
  logic [SEL_W-1:0]  r_ch, w_ch_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic [W-1:0]      w_dsel_data;
  logic [N_CH-1:0]   w_src, w_lo_onehot;
  logic [SEL_W-1:0]  w_lo_idx;
  logic [W-1:0]      w_lo_data;
  logic              w_lo_found;
  logic              w_hs;

  assign w_hs = r_valid & out_ready;

  // Out-of-range sel matches no channel and yields zero.
  always_comb begin
    w_dsel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) w_dsel_data = din[i*W +: W];
    end
  end

  // r_mask holds only the channels not yet emitted, so "next higher enabled"
  // is simply its lowest set bit.
  assign w_src       = (r_state == S_SCAN) ? r_mask : en_mask;
  assign w_lo_onehot = w_src & (~w_src + N_CH'(1));

  always_comb begin
    w_lo_idx   = '0;
    w_lo_data  = '0;
    w_lo_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        w_lo_idx   = SEL_W'(i);
        w_lo_data  = din[i*W +: W];
        w_lo_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!mode)                      w_state_nxt = S_DSEL;
        else if (start && w_lo_found)   w_state_nxt = S_SCAN;
      end
      S_DSEL: if (mode)                 w_state_nxt = S_IDLE;
      S_SCAN: if (w_hs && !w_lo_found)  w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mask_nxt  = r_mask;
    w_data_nxt  = r_data;
    w_ch_nxt    = r_ch;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (mode && start) begin
          if (w_lo_found) begin
            w_mask_nxt  = w_src ^ w_lo_onehot;
            w_data_nxt  = w_lo_data;
            w_ch_nxt    = w_lo_idx;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_mask_nxt  = '0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_DSEL: begin
        if (mode) begin
          w_valid_nxt = 1'b0;
        end else begin
          w_data_nxt  = w_dsel_data;
          w_ch_nxt    = sel;
          w_valid_nxt = 1'b1;
        end
      end
      S_SCAN: begin
        if (w_hs) begin
          if (w_lo_found) begin
            w_mask_nxt = w_src ^ w_lo_onehot;
            w_data_nxt = w_lo_data;
            w_ch_nxt   = w_lo_idx;
          end else begin
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask  <= '0;
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_mask  <= w_mask_nxt;
      r_data  <= w_data_nxt;
      r_ch    <= w_ch_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomized checks of mux_scan_n against an ordered-channel-list model:
// an 8x8-bit instance for most behaviour, a 5x1-bit instance for out-of-range sel.
module tb_mux_scan_n;

  localparam int N = 8;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [2:0]  sel = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0]   en_mask = '0;
  logic [W-1:0]   out_data;
  logic [2:0]     out_ch;
  logic           out_valid, busy, done;

  logic        mode5 = 1'b1, start5 = 1'b0, ready5 = 1'b0;
  logic [2:0]  sel5 = '0;
  logic [4:0]  din5 = '0;
  logic [4:0]  mask5 = '0;
  logic [0:0]  data5;
  logic [2:0]  ch5;
  logic        valid5, busy5, done5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.N_CH(N), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .din(din),
    .en_mask(en_mask), .start(start), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  mux_scan_n #(.N_CH(5), .W(1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5), .din(din5),
    .en_mask(mask5), .start(start5), .out_data(data5), .out_ch(ch5),
    .out_valid(valid5), .out_ready(ready5), .busy(busy5), .done(done5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ch_of(input logic [N*W-1:0] d, input int c);
    return d[c*W +: W];
  endfunction

  function automatic logic [N*W-1:0] rand_din();
    logic [N*W-1:0] d;
    d = {$urandom, $urandom};
    return d;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  // Scan model: ordered list of enabled channels; each sample is the channel
  // value present on din at the clock edge that loads it.
  task automatic run_scan(input logic [N-1:0] m, input bit rand_ready);
    int q[$];
    int k;
    int guard;
    logic [W-1:0] exp_d;
    for (int i = 0; i < N; i++) if (m[i]) q.push_back(i);
    @(negedge clk);
    mode = 1'b1; en_mask = m; start = 1'b1; din = rand_din();
    if (q.size() > 0) exp_d = ch_of(din, q[0]);
    @(negedge clk);
    start = 1'b0;
    if (q.size() == 0) begin
      chk("empty_done", done, 1);
      chk("empty_valid", out_valid, 0);
      chk("empty_busy", busy, 0);
      @(negedge clk);
      chk("empty_done_pulse", done, 0);
      chk("empty_valid2", out_valid, 0);
      return;
    end
    k = 0;
    guard = 0;
    while (k < q.size() && guard < 200) begin
      guard++;
      chk("scan_valid", out_valid, 1);
      chk("scan_busy", busy, 1);
      chk("scan_done_low", done, 0);
      chk("scan_ch", out_ch, q[k]);
      chk("scan_data", out_data, exp_d);
      en_mask = N'($urandom);
      start = $urandom_range(0, 1);
      mode = $urandom_range(0, 1);
      din = rand_din();
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        k++;
        if (k < q.size()) exp_d = ch_of(din, q[k]);
      end
      @(negedge clk);
    end
    chk("scan_guard", guard < 200, 1);
    out_ready = 1'b0; start = 1'b0; mode = 1'b1;
    chk("end_done", done, 1);
    chk_idle_outputs("end");
    @(negedge clk);
    chk("end_done_pulse", done, 0);
    chk("end_valid2", out_valid, 0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [2:0] psel;
    logic [N*W-1:0] pdin;

    #2;
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk_idle_outputs("rst");
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("idle");

    // Direct mode with the fixed 0xA6 pattern, then random sel/din.
    mode = 1'b0;
    @(negedge clk);
    pat = 8'b1010_0110;
    din = '0;
    for (int i = 0; i < N; i++) din[i*W] = pat[i];
    for (int i = 0; i < N + 20; i++) begin
      psel = (i < N) ? 3'(i) : 3'($urandom);
      if (i >= N) din = rand_din();
      sel = psel; pdin = din;
      start = $urandom_range(0, 1);
      @(negedge clk);
      chk("dsel_data", out_data, ch_of(pdin, psel));
      chk("dsel_ch", out_ch, psel);
      chk("dsel_valid", out_valid, 1);
      chk("dsel_done", done, 0);
      chk("dsel_busy", busy, 0);
    end
    mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_idle_outputs("dsel_exit");
    @(negedge clk);
    chk_idle_outputs("dsel_exit2");
    chk("dsel_exit_done", done, 0);

    run_scan(8'hFF, 1'b0);
    run_scan(8'b1001_0100, 1'b1);
    run_scan(8'h00, 1'b0);
    for (int t = 0; t < 6; t++) run_scan(N'($urandom), 1'b1);
    run_scan(8'h80, 1'b1);
    run_scan(8'h01, 1'b0);

    // Reset in the middle of a full-mask scan, after ch3 is accepted.
    @(negedge clk);
    mode = 1'b1; en_mask = 8'hFF; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_ch", out_ch, 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", out_data, 0);
    chk("midrst_ch", out_ch, 0);
    chk_idle_outputs("midrst");
    chk("midrst_done", done, 0);
    @(negedge clk);
    chk("midrst_done2", done, 0);
    rst_n = 1'b1; out_ready = 1'b0;
    run_scan(8'hFF, 1'b1);

    // Out-of-range sel on the five-channel instance.
    mode5 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      psel = 3'($urandom);
      sel5 = psel; din5 = 5'($urandom); start5 = $urandom_range(0, 1);
      pdin = '0;
      pdin[4:0] = din5;
      @(negedge clk);
      chk("n5_data", data5, (psel < 5) ? pdin[psel] : 1'b0);
      chk("n5_ch", ch5, psel);
      chk("n5_valid", valid5, 1);
      chk("n5_done", done5, 0);
      chk("n5_busy", busy5, 0);
    end
    sel5 = 3'd6; din5 = 5'h1F; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    chk("n5_sel6_data", data5, 0);
    chk("n5_sel6_ch", ch5, 6);
    chk("n5_sel6_done", done5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
